// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage.
//   - Default datapath width and register index width.
//   - ALU opcode encodings driven onto alu_opcode.
package alu_issue_stage_pkg;

  localparam int WORD_SIZE_DEF  = 64;
  localparam int REG_COUNT_DEF  = 16;
  localparam int REG_ADDR_W_DEF = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_AND  = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_NOR  = 4'b0110,
    OP_NAND = 4'b0111,
    OP_XNOR = 4'b1000,
    OP_SHL  = 4'b1001,
    OP_SHR  = 4'b1010,
    OP_PASS = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/alu_issue_stage_regfile_2r1w.sv
// Architectural register file: two combinational read ports, one debug
// read port and one synchronous write port. r0 always reads as zero and
// is never written.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears all regs)
//   we, waddr, wdata  write port, applied on the rising edge
//   raddr1/rdata1     operand read port 1
//   raddr2/rdata2     operand read port 2
//   dbg_addr/dbg_data debug read port
module regfile_2r1w
  import alu_issue_stage_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int REG_COUNT  = REG_COUNT_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [WORD_SIZE-1:0]  wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  output logic [WORD_SIZE-1:0]  rdata1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [WORD_SIZE-1:0]  rdata2,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [WORD_SIZE-1:0]  dbg_data
);

  logic [WORD_SIZE-1:0] mem_q [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // r0 is masked on read so it stays zero regardless of storage contents.
  assign rdata1   = (raddr1   == '0) ? '0 : mem_q[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : mem_q[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage in front of a combinational ALU.
// Accepts decoded instructions (valid/ready), reads operands from the
// register file with write-back forwarding, and registers d1/d2/opcode
// into the pipeline register driving the ALU. One edge later the ALU
// result is written to rd and the zero/carry flags are latched.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           instruction handshake (in_ready = ~hold)
//   in_opcode, in_rd, in_rs1,
//   in_rs2, in_imm_sel, in_imm  decoded instruction fields
//   hold                        downstream freeze request
//   alu_d1, alu_d2, alu_opcode  registered ALU inputs
//   alu_out, alu_iszero,
//   alu_iscarry                 ALU results
//   issue_valid                 pipeline register holds a live instruction
//   zero_flag, carry_flag       flags of the last retired instruction
//   dbg_addr/dbg_data           combinational register read, no forwarding
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int REG_COUNT  = REG_COUNT_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_imm_sel,
  input  logic [WORD_SIZE-1:0]  in_imm,
  input  logic                  hold,
  output logic [WORD_SIZE-1:0]  alu_d1,
  output logic [WORD_SIZE-1:0]  alu_d2,
  output logic [3:0]            alu_opcode,
  input  logic [WORD_SIZE-1:0]  alu_out,
  input  logic                  alu_iszero,
  input  logic                  alu_iscarry,
  output logic                  issue_valid,
  output logic                  zero_flag,
  output logic                  carry_flag,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [WORD_SIZE-1:0]  dbg_data
);

  logic                  issue_valid_q;
  logic [WORD_SIZE-1:0]  alu_d1_q, alu_d1_d;
  logic [WORD_SIZE-1:0]  alu_d2_q, alu_d2_d;
  logic [3:0]            alu_opcode_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  zero_flag_q;
  logic                  carry_flag_q;

  logic                  accept;
  logic                  wb;
  logic [WORD_SIZE-1:0]  rs1_data, rs2_data;

  assign in_ready = ~hold;
  assign accept   = in_valid & in_ready;
  // Retirement happens whenever a live instruction sees an unfrozen edge.
  assign wb       = issue_valid_q & ~hold;

  regfile_2r1w #(
    .WORD_SIZE (WORD_SIZE),
    .REG_COUNT (REG_COUNT),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb),
    .waddr   (rd_q),
    .wdata   (alu_out),
    .raddr1  (in_rs1),
    .rdata1  (rs1_data),
    .raddr2  (in_rs2),
    .rdata2  (rs2_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  // Forward the result being written on this same edge; r0 is never
  // forwarded because its write is dropped.
  always_comb begin
    alu_d1_d = rs1_data;
    alu_d2_d = rs2_data;
    if (wb && (rd_q == in_rs1) && (in_rs1 != '0)) begin
      alu_d1_d = alu_out;
    end
    if (wb && (rd_q == in_rs2) && (in_rs2 != '0)) begin
      alu_d2_d = alu_out;
    end
    if (in_imm_sel) begin
      alu_d2_d = in_imm;
    end
  end

  // Issue / write-back stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_q <= 1'b0;
      alu_d1_q      <= '0;
      alu_d2_q      <= '0;
      alu_opcode_q  <= OP_PASS;
      rd_q          <= '0;
      zero_flag_q   <= 1'b0;
      carry_flag_q  <= 1'b0;
    end else if (!hold) begin
      issue_valid_q <= in_valid;
      if (accept) begin
        alu_d1_q     <= alu_d1_d;
        alu_d2_q     <= alu_d2_d;
        alu_opcode_q <= in_opcode;
        rd_q         <= in_rd;
      end
      if (issue_valid_q) begin
        zero_flag_q  <= alu_iszero;
        carry_flag_q <= alu_iscarry;
      end
    end
  end

  assign issue_valid = issue_valid_q;
  assign alu_d1      = alu_d1_q;
  assign alu_d2      = alu_d2_q;
  assign alu_opcode  = alu_opcode_q;
  assign zero_flag   = zero_flag_q;
  assign carry_flag  = carry_flag_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int W  = 64;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [AW-1:0] in_rd, in_rs1, in_rs2;
  logic          in_imm_sel;
  logic [W-1:0]  in_imm;
  logic          hold;
  logic [W-1:0]  alu_d1, alu_d2;
  logic [3:0]    alu_opcode;
  logic [W-1:0]  alu_out;
  logic          alu_iszero, alu_iscarry;
  logic          issue_valid, zero_flag, carry_flag;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [3:0]   op;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm_sel (in_imm_sel),
    .in_imm     (in_imm),
    .hold       (hold),
    .alu_d1     (alu_d1),
    .alu_d2     (alu_d2),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_iszero (alu_iszero),
    .alu_iscarry(alu_iscarry),
    .issue_valid(issue_valid),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Behavioural ALU so the stage has a real result to write back.
  logic [W:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (alu_opcode)
      OP_ADD:  alu_wide = {1'b0, alu_d1} + {1'b0, alu_d2};
      OP_SUB:  alu_wide = {1'b0, alu_d1} - {1'b0, alu_d2};
      OP_OR:   alu_wide = {1'b0, alu_d1 | alu_d2};
      OP_AND:  alu_wide = {1'b0, alu_d1 & alu_d2};
      OP_XOR:  alu_wide = {1'b0, alu_d1 ^ alu_d2};
      OP_PASS: alu_wide = {1'b0, alu_d1};
      default: alu_wide = '0;
    endcase
  end
  assign alu_out     = alu_wide[W-1:0];
  assign alu_iscarry = alu_wide[W];
  assign alu_iszero  = (alu_wide[W-1:0] == '0);

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an instruction retires on a sampled cycle with issue_valid=1,
  // hold=0 and no reset; its registered operands must match the queue head.
  always @(negedge clk) begin
    if (!rst && issue_valid && !hold) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: got unexpected retirement d1=%0h d2=%0h", alu_d1, alu_d2);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_d1", alu_d1, e.d1);
        check("sb_d2", alu_d2, e.d2);
        check("sb_op", {60'd0, alu_opcode}, {60'd0, e.op});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                       input logic isel, input logic [W-1:0] imm,
                       input logic [W-1:0] ed1, input logic [W-1:0] ed2, input bit push);
    exp_t e;
    in_valid   = 1'b1;
    in_opcode  = op;
    in_rd      = AW'(rd);
    in_rs1     = AW'(rs1);
    in_rs2     = AW'(rs2);
    in_imm_sel = isel;
    in_imm     = imm;
    if (push) begin
      e.d1 = ed1; e.d2 = ed2; e.op = op;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reg(input int idx, input logic [W-1:0] exp);
    dbg_addr = AW'(idx);
    #1;
    check($sformatf("dbg_r%0d", idx), dbg_data, exp);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; in_valid = 1'b0; in_opcode = 4'd0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm_sel = 1'b0; in_imm = '0; dbg_addr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Reset state
    check("rst_issue_valid", {63'd0, issue_valid}, 64'd0);
    check("rst_opcode", {60'd0, alu_opcode}, 64'hF);
    check("rst_zero", {63'd0, zero_flag}, 64'd0);
    check("rst_carry", {63'd0, carry_flag}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 16; i++) check_reg(i, 64'd0);

    // Load immediate r1 = 0 + 5
    issue(OP_ADD, 1, 0, 0, 1'b1, 64'd5, 64'd0, 64'd5, 1'b1);
    check("li_d1", alu_d1, 64'd0);
    check("li_d2", alu_d2, 64'd5);
    // r2 = r1 + 3, r1 forwarded from the write-back on this edge
    issue(OP_ADD, 2, 1, 0, 1'b1, 64'd3, 64'd5, 64'd3, 1'b1);
    check_reg(1, 64'd5);
    // r3 = r2 + r2, both forwarded
    issue(OP_ADD, 3, 2, 2, 1'b0, 64'd0, 64'd8, 64'd8, 1'b1);
    idle(1);
    check_reg(2, 64'd8);
    check_reg(3, 64'd16);

    // Non-forwarded reads: r5 = r1 + r3 = 21
    issue(OP_ADD, 5, 1, 3, 1'b0, 64'd0, 64'd5, 64'd16, 1'b1);
    // r4 = r1 - 5 = 0 -> zero flag
    issue(OP_SUB, 4, 1, 0, 1'b1, 64'd5, 64'd5, 64'd5, 1'b1);
    idle(1);
    check_reg(5, 64'd21);
    check_reg(4, 64'd0);
    check("sub_zero", {63'd0, zero_flag}, 64'd1);
    check("sub_carry", {63'd0, carry_flag}, 64'd0);

    // Carry: r6 = all ones, r7 = r6 + 1 = 0 with carry
    issue(OP_ADD, 6, 0, 0, 1'b1, {W{1'b1}}, 64'd0, {W{1'b1}}, 1'b1);
    issue(OP_ADD, 7, 6, 0, 1'b1, 64'd1, {W{1'b1}}, 64'd1, 1'b1);
    idle(1);
    check_reg(6, {W{1'b1}});
    check_reg(7, 64'd0);
    check("add_carry", {63'd0, carry_flag}, 64'd1);
    check("add_zero", {63'd0, zero_flag}, 64'd1);

    // Write to r0 is dropped, flags still update, no forwarding from r0
    issue(OP_ADD, 0, 0, 0, 1'b1, 64'd7, 64'd0, 64'd7, 1'b1);
    issue(OP_ADD, 8, 0, 0, 1'b1, 64'd1, 64'd0, 64'd1, 1'b1);
    check("r0wr_zero", {63'd0, zero_flag}, 64'd0);
    check("r0wr_carry", {63'd0, carry_flag}, 64'd0);
    check_reg(0, 64'd0);
    idle(1);
    check_reg(8, 64'd1);

    // Hold: r9 = r8 + 10 = 11, frozen for three edges
    issue(OP_ADD, 9, 8, 0, 1'b1, 64'd10, 64'd1, 64'd10, 1'b1);
    hold = 1'b1;
    // A competing instruction that must not be accepted while held
    in_valid = 1'b1; in_opcode = OP_XOR; in_rd = AW'(10); in_rs1 = AW'(3);
    in_imm_sel = 1'b1; in_imm = 64'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      check("hold_d1", alu_d1, 64'd1);
      check("hold_d2", alu_d2, 64'd10);
      check("hold_op", {60'd0, alu_opcode}, {60'd0, OP_ADD});
      check("hold_valid", {63'd0, issue_valid}, 64'd1);
      check_reg(9, 64'd0);
    end
    hold = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_reg(9, 64'd11);
    check_reg(10, 64'd0);
    check("post_hold_valid", {63'd0, issue_valid}, 64'd0);
    idle(1);
    check_reg(9, 64'd11);

    // Reset with an instruction in flight: r10 = 99 must never land
    issue(OP_ADD, 10, 0, 0, 1'b1, 64'd99, 64'd0, 64'd99, 1'b0);
    check("inflight_valid", {63'd0, issue_valid}, 64'd1);
    rst = 1'b1;
    hold = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    hold = 1'b0;
    check("rst2_issue_valid", {63'd0, issue_valid}, 64'd0);
    check("rst2_opcode", {60'd0, alu_opcode}, 64'hF);
    check("rst2_d2", alu_d2, 64'd0);
    check("rst2_zero", {63'd0, zero_flag}, 64'd0);
    check_reg(10, 64'd0);
    check_reg(9, 64'd0);
    idle(2);
    check_reg(10, 64'd0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage that sits directly upstream of the combinational ALU.
- Accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file.
- Registers d1/d2/opcode into a pipeline register that drives the ALU.
- One cycle later, writes the ALU result back to the destination register and latches the iszero/iscarry flags.
- Provides same-edge write-back forwarding so back-to-back dependent instructions issue without stalls.

Parameters:
- WORD_SIZE, 64, datapath width; must match the ALU.
- REG_COUNT, 16, number of architectural registers.
- REG_ADDR_W, 4, register index width; equals clog2(REG_COUNT).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  instruction present.
- in_ready  output  1  stage can accept; equals ~hold.
- in_opcode  input  4  ALU opcode, passed through unchanged.
- in_rd  input  REG_ADDR_W  destination register.
- in_rs1  input  REG_ADDR_W  source register for d1.
- in_rs2  input  REG_ADDR_W  source register for d2 when in_imm_sel=0.
- in_imm_sel  input  1  1: d2 comes from in_imm.
- in_imm  input  WORD_SIZE  immediate operand.
- hold  input  1  downstream freeze request.
- alu_d1  output  WORD_SIZE  registered operand 1 to ALU.
- alu_d2  output  WORD_SIZE  registered operand 2 to ALU.
- alu_opcode  output  4  registered opcode to ALU.
- alu_out  input  WORD_SIZE  ALU result.
- alu_iszero  input  1  ALU zero flag.
- alu_iscarry  input  1  ALU carry flag.
- issue_valid  output  1  pipeline register holds a live instruction.
- zero_flag  output  1  latched iszero of the last retired instruction.
- carry_flag  output  1  latched iscarry of the last retired instruction.
- dbg_addr  input  REG_ADDR_W  debug read index.
- dbg_data  output  WORD_SIZE  combinational register-file read; no forwarding.

Behaviour:
- Reset (synchronous, active-high), on a rising edge with rst=1:
  - All registers r0..r(REG_COUNT-1) are cleared to 0.
  - issue_valid=0, alu_d1=0, alu_d2=0, alu_opcode=4'b1111 (ALU passthrough default), zero_flag=0, carry_flag=0, rd_q=0.
  - Reset overrides hold and in_valid. An instruction in flight when reset asserts is discarded, with no write-back.
- r0 reads as 0 at all times. Writes to r0 are dropped, but the flags are still updated.
- Accept condition: accept = in_valid & in_ready.
- Edge update when hold=0:
  - issue_valid <= in_valid.
  - If accepted: alu_d1 <= fwd(in_rs1); alu_d2 <= in_imm_sel ? in_imm : fwd(in_rs2); alu_opcode <= in_opcode; rd_q <= in_rd.
  - If not accepted: operand and opcode registers keep their previous values.
- Write-back, when issue_valid=1 and hold=0 at the edge:
  - reg[rd_q] <= alu_out, unless rd_q=0.
  - zero_flag <= alu_iszero; carry_flag <= alu_iscarry.
- Forwarding: fwd(x) = alu_out when a write-back occurs on this edge, rd_q==x and x!=0; otherwise reg[x].
- Hold=1:
  - Pipeline register, register file and flags are all frozen, and in_ready=0.
  - The ALU continues to see stable operands, so write-back happens on the first edge with hold=0.
- Latency: instruction accepted at edge N → ALU output valid during cycle N+1 → register and flags written at edge N+1.
- Throughput is one instruction per cycle; there are no dependency stalls.
- Simultaneous write-back to rd and accept of an instruction reading rd: the new instruction receives the forwarded value.
- Bubble (in_valid=0, hold=0): issue_valid drops to 0 and the next edge performs no write-back.
- Arithmetic: the stage performs no arithmetic; all widths are WORD_SIZE with no truncation.

Decomposition:
- Shared package/header holds:
  - WORD_SIZE and REG_ADDR_W defaults.
  - ALU opcode constants: ADD=0000, SUB=0001, MUL=0010, OR=0011, AND=0100, XOR=0101, NOR=0110, NAND=0111, XNOR=1000, SHL=1001, SHR=1010, PASS=1111.
- One sub-module, regfile_2r1w: two combinational read ports plus the debug port, one synchronous write port, r0 hardwired to zero.
- Forwarding mux and pipeline register live in the top level.

Test Plan:
- Reset then idle → issue_valid=0, alu_opcode=1111, flags 0, dbg_data=0 for every index.
- Load immediate: issue PASS-style ADD with rs1=r0, imm_sel=1, imm=5, rd=r1 → alu_d1=0, alu_d2=5 one edge later; dbg r1=5 after the next edge.
- Back-to-back dependency: ADD r2=r1+imm3, then immediately ADD r3=r2+r2 → alu_d1=alu_d2=8 via forwarding, so r3=16. Also verify the non-forwarded path reads r1=5.
- Flags: SUB with r1=5 and imm=5 into r4 → zero_flag=1, r4=0. ADD of 64'hFFFF_FFFF_FFFF_FFFF plus imm 1 → carry_flag=1 and the result is 0.
- Write to r0: ADD imm 7 → rd=r0 → r0 still reads 0, and a following instruction reading r0 gets 0 (no forwarding).
- Hold for 3 cycles mid-stream, then reset asserted with issue_valid=1 → while held: in_ready=0, alu_* stable, no register change. After release, write-back occurs exactly once. Under reset, the in-flight result is never written.
